nic_ctrl: RTL and testbench

Network interface controller between the cpu's NIC port and one Cardinal ring router node. It exposes four 2-bit-addressed registers to the cpu: input buffer, input status, output buffer and output status. Toward the router, it holds one single-entry channel buffer per direction with a send/ready handshake, gated by the ring polarity. One instance is placed per node, alongside the cpu, imem and dmem.

---
 rtl/nic_pkg.sv | 12 +
 rtl/nic_chan_buf.sv | 44 ++++
 rtl/nic_ctrl.sv | 79 +++++++
 tb/tb_nic_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nic_pkg.sv
// Shared constants for the NIC: cpu register map, packet width and VC bit position.
package nic_pkg;

    localparam int unsigned NIC_DATA_WIDTH = 64;
    localparam int unsigned NIC_VC_BIT     = 0;

    localparam logic [1:0] NIC_ADDR_ICB      = 2'b00;
    localparam logic [1:0] NIC_ADDR_ICB_STAT = 2'b01;
    localparam logic [1:0] NIC_ADDR_OCB      = 2'b10;
    localparam logic [1:0] NIC_ADDR_OCB_STAT = 2'b11;

endpackage

// File: rtl/nic_chan_buf.sv
// Single-entry channel buffer: one data register plus a full flag.
module nic_chan_buf #(
    parameter int unsigned Width = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_i,
    input  logic             rd_i,
    input  logic [0:Width-1] data_i,
    output logic [0:Width-1] data_o,
    output logic             full_o
);

    logic [0:Width-1] data_q, data_d;
    logic             full_q, full_d;

    // A write only lands in an empty buffer; a read only empties a full one.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (full_q) begin
            if (rd_i) begin
                full_d = 1'b0;
            end
        end else if (wr_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/nic_ctrl.sv
// NIC between the cpu register port and a ring router node: ICB/OCB buffers,
// cpu read mux, router handshake and polarity-gated send.
module nic_ctrl
    import nic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NIC_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ADDR_WIDTH-1] nicAddr,
    input  logic [0:DATA_WIDTH-1] nicDataIn,
    output logic [0:DATA_WIDTH-1] nicDataOut,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    logic                  icb_full, ocb_full;
    logic [0:DATA_WIDTH-1] icb_data, ocb_data;
    logic                  cpu_rd, cpu_wr;
    logic                  icb_wr, icb_rd, ocb_wr;

    assign cpu_rd = nicEn & ~nicWrEn;
    assign cpu_wr = nicEn & nicWrEn;

    assign net_ri = ~icb_full & ~reset;
    assign icb_wr = net_si & net_ri;
    assign icb_rd = cpu_rd & (nicAddr == NIC_ADDR_ICB);
    assign ocb_wr = cpu_wr & (nicAddr == NIC_ADDR_OCB);

    // Only the VC matching the current ring polarity may be injected.
    assign net_so = ocb_full & net_ro & (ocb_data[NIC_VC_BIT] == net_polarity) & ~reset;
    assign net_do = ocb_data;

    nic_chan_buf #(
        .Width (DATA_WIDTH)
    ) u_icb (
        .clk    (clk),
        .reset  (reset),
        .wr_i   (icb_wr),
        .rd_i   (icb_rd),
        .data_i (net_di),
        .data_o (icb_data),
        .full_o (icb_full)
    );

    nic_chan_buf #(
        .Width (DATA_WIDTH)
    ) u_ocb (
        .clk    (clk),
        .reset  (reset),
        .wr_i   (ocb_wr),
        .rd_i   (net_so),
        .data_i (nicDataIn),
        .data_o (ocb_data),
        .full_o (ocb_full)
    );

    always_comb begin
        nicDataOut = '0;
        if (cpu_rd) begin
            case (nicAddr)
                NIC_ADDR_ICB:      nicDataOut = icb_data;
                NIC_ADDR_ICB_STAT: nicDataOut = {{(DATA_WIDTH-1){1'b0}}, icb_full};
                NIC_ADDR_OCB:      nicDataOut = ocb_data;
                NIC_ADDR_OCB_STAT: nicDataOut = {{(DATA_WIDTH-1){1'b0}}, ocb_full};
                default:           nicDataOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nic_ctrl.sv
// Self-checking bench for nic_ctrl: directed scenarios plus random traffic
// against a buffer-level reference model.
module tb_nic_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [0:1]  nicAddr = 2'b00;
    logic [0:63] nicDataIn = '0;
    logic [0:63] nicDataOut;
    logic        nicEn = 1'b0;
    logic        nicWrEn = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [0:63] net_di = '0;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [0:63] net_do;
    logic        net_polarity = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    nic_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .nicAddr      (nicAddr),
        .nicDataIn    (nicDataIn),
        .nicDataOut   (nicDataOut),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    // Reference model: two one-slot mailboxes, data kept in plain [63:0] order.
    bit          m_icb_full, m_ocb_full;
    logic [63:0] m_icb_data, m_ocb_data;

    function automatic bit exp_ri();
        return !m_icb_full && !reset;
    endfunction

    function automatic bit exp_so();
        return m_ocb_full && net_ro && !reset && (m_ocb_data[63] == net_polarity);
    endfunction

    function automatic logic [63:0] exp_out();
        if (!(nicEn && !nicWrEn)) return 64'd0;
        case (nicAddr)
            2'b00:   return m_icb_data;
            2'b01:   return {63'd0, m_icb_full};
            2'b10:   return m_ocb_data;
            default: return {63'd0, m_ocb_full};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_icb_full = 0;
            m_ocb_full = 0;
            m_icb_data = '0;
            m_ocb_data = '0;
        end else begin
            bit arrive, drain_icb, send, put;
            arrive    = net_si && exp_ri();
            drain_icb = nicEn && !nicWrEn && nicAddr == 2'b00 && m_icb_full;
            send      = exp_so();
            put       = nicEn && nicWrEn && nicAddr == 2'b10 && !m_ocb_full;
            if (arrive) begin
                m_icb_data = net_di;
                m_icb_full = 1;
            end
            if (drain_icb) m_icb_full = 0;
            if (send) m_ocb_full = 0;
            else if (put) begin
                m_ocb_data = nicDataIn;
                m_ocb_full = 1;
            end
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_ri", {63'd0, net_ri}, {63'd0, exp_ri()});
            cmp("model_so", {63'd0, net_so}, {63'd0, exp_so()});
            cmp("model_do", net_do, m_ocb_data);
            cmp("model_out", nicDataOut, exp_out());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input bit en, input bit wr, input logic [1:0] a, input logic [63:0] d);
        nicEn     = en;
        nicWrEn   = wr;
        nicAddr   = a;
        nicDataIn = d;
    endtask

    initial begin
        // Reset asserted mid-cycle and held three cycles.
        #2 reset = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_ri", {63'd0, net_ri}, 64'd0);
        cmp("rst_so", {63'd0, net_so}, 64'd0);
        cmp("rst_do", net_do, 64'd0);
        cmp("rst_out", nicDataOut, 64'd0);
        step();
        reset = 1'b0;
        cpu(1, 0, 2'b01, '0);
        @(negedge clk);
        cmp("rel_ri", {63'd0, net_ri}, 64'd1);
        cmp("rel_stat01", nicDataOut, 64'd0);
        #1 nicAddr = 2'b11;
        #1 cmp("rel_stat11", nicDataOut, 64'd0);

        // Router to cpu.
        step();
        cpu(0, 0, 2'b00, '0);
        net_si = 1'b1;
        net_di = 64'hA5A5_0000_0000_0001;
        step();
        net_si = 1'b0;
        cpu(1, 0, 2'b01, '0);
        @(negedge clk);
        cmp("icb_ri_low", {63'd0, net_ri}, 64'd0);
        cmp("icb_stat", nicDataOut, 64'h1);
        #1 nicAddr = 2'b00;
        #1 cmp("icb_data", nicDataOut, 64'hA5A5_0000_0000_0001);
        step();
        nicAddr = 2'b01;
        @(negedge clk);
        cmp("icb_ri_back", {63'd0, net_ri}, 64'd1);
        cmp("icb_stat_clr", nicDataOut, 64'd0);

        // cpu to router, waiting on polarity.
        step();
        cpu(1, 1, 2'b10, 64'h8000_0000_0000_00FF);
        net_ro = 1'b1;
        net_polarity = 1'b0;
        step();
        cpu(0, 0, 2'b00, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("pol_wait_so", {63'd0, net_so}, 64'd0);
            step();
        end
        net_polarity = 1'b1;
        @(negedge clk);
        cmp("pol_send_so", {63'd0, net_so}, 64'd1);
        cmp("pol_send_do", net_do, 64'h8000_0000_0000_00FF);
        step();
        cpu(1, 0, 2'b11, '0);
        @(negedge clk);
        cmp("pol_after_so", {63'd0, net_so}, 64'd0);
        cmp("pol_stat11", nicDataOut, 64'd0);

        // Backpressure: second write is dropped.
        step();
        net_ro = 1'b0;
        net_polarity = 1'b0;
        cpu(1, 1, 2'b10, 64'h1);
        step();
        cpu(1, 1, 2'b10, 64'h2);
        step();
        cpu(1, 0, 2'b10, '0);
        @(negedge clk);
        cmp("bp_data", nicDataOut, 64'h1);
        step();
        cpu(0, 0, 2'b00, '0);
        net_ro = 1'b1;
        @(negedge clk);
        cmp("bp_send_so", {63'd0, net_so}, 64'd1);
        cmp("bp_send_do", net_do, 64'h1);
        step();
        @(negedge clk);
        cmp("bp_once", {63'd0, net_so}, 64'd0);

        // Write coinciding with a send is dropped.
        step();
        net_ro = 1'b0;
        cpu(1, 1, 2'b10, 64'h4);
        step();
        net_ro = 1'b1;
        cpu(1, 1, 2'b10, 64'h3);
        @(negedge clk);
        cmp("sim_so", {63'd0, net_so}, 64'd1);
        step();
        cpu(1, 0, 2'b11, '0);
        net_ro = 1'b0;
        @(negedge clk);
        cmp("sim_stat11", nicDataOut, 64'd0);
        #1 nicAddr = 2'b10;
        #1 cmp("sim_data", nicDataOut, 64'h4);

        // Reset with both buffers holding data.
        step();
        net_si = 1'b1;
        net_di = 64'h1234_5678_9ABC_DEF0;
        net_ro = 1'b1;
        net_polarity = 1'b0;
        cpu(1, 1, 2'b10, 64'hC000_0000_0000_0007);
        step();
        net_si = 1'b0;
        cpu(0, 0, 2'b00, '0);
        @(negedge clk);
        cmp("mid_ri_low", {63'd0, net_ri}, 64'd0);
        #1 reset = 1'b1;
        step();
        step();
        cpu(1, 0, 2'b01, '0);
        net_polarity = 1'b1;
        @(negedge clk);
        cmp("mid_stat01", nicDataOut, 64'd0);
        cmp("mid_so", {63'd0, net_so}, 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        cmp("mid_ri_back", {63'd0, net_ri}, 64'd1);
        cmp("mid_no_send", {63'd0, net_so}, 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step();
            reset        = ($urandom_range(0, 59) == 0);
            net_si       = $urandom_range(0, 1);
            net_di       = {$urandom, $urandom};
            net_ro       = $urandom_range(0, 3) != 0;
            net_polarity = $urandom_range(0, 1);
            cpu($urandom_range(0, 2) != 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                {$urandom, $urandom});
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
